// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - shared DP word layout, 1080p timing defaults and FSM state type
//
// Purpose: constants and types common to the DP timing source and its raster counter.
// Ports: none (package).

package dp_pkg;

  // Bit positions inside the 27-bit DP word {hsync,vsync,de,R,G,B}
  localparam int DP_W    = 27;
  localparam int DP_HS   = 26;
  localparam int DP_VS   = 25;
  localparam int DP_DE   = 24;
  localparam int DP_R_HI = 23;
  localparam int DP_R_LO = 16;
  localparam int DP_G_HI = 15;
  localparam int DP_G_LO = 8;
  localparam int DP_B_HI = 7;
  localparam int DP_B_LO = 0;

  // 1080p raster defaults
  localparam int DP_H_ACT  = 1920;
  localparam int DP_H_FP   = 88;
  localparam int DP_H_SYNC = 44;
  localparam int DP_H_BP   = 148;
  localparam int DP_V_ACT  = 1080;
  localparam int DP_V_FP   = 4;
  localparam int DP_V_SYNC = 5;
  localparam int DP_V_BP   = 36;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    RUN      = 2'd2,
    RESYNC   = 2'd3
  } dp_state_e;

endpackage

// File: rtl/dp_raster_cnt.sv
// rtl/dp_raster_cnt.sv - h/v raster counters with de/hsync/vsync decode
//
// Purpose: free-running raster position while enabled, held at the origin otherwise.
// Ports:
//   clk_i          pixel clock
//   rst_ni         synchronous active-low reset
//   en_i           0 holds the raster at (0,0)
//   de_o           active video at the current position
//   hsync_o        horizontal sync (active-high)
//   vsync_o        vertical sync, whole lines (active-high)
//   frame_start_o  current position is (h=0,v=0)

module dp_raster_cnt
  import dp_pkg::*;
#(
  parameter int H_ACT  = DP_H_ACT,
  parameter int H_FP   = DP_H_FP,
  parameter int H_SYNC = DP_H_SYNC,
  parameter int H_BP   = DP_H_BP,
  parameter int V_ACT  = DP_V_ACT,
  parameter int V_FP   = DP_V_FP,
  parameter int V_SYNC = DP_V_SYNC,
  parameter int V_BP   = DP_V_BP
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic de_o,
  output logic hsync_o,
  output logic vsync_o,
  output logic frame_start_o
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  // Sync windows are expressed as inclusive first/last positions so every
  // constant fits the counter width even when the back porch is zero.
  localparam logic [HW-1:0] H_ONE     = HW'(1);
  localparam logic [VW-1:0] V_ONE     = VW'(1);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOT - 1);
  localparam logic [HW-1:0] H_ACT_C   = HW'(H_ACT);
  localparam logic [VW-1:0] V_ACT_C   = VW'(V_ACT);
  localparam logic [HW-1:0] H_HS_BEG  = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] H_HS_LAST = HW'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_VS_BEG  = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] V_VS_LAST = VW'(V_ACT + V_FP + V_SYNC - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!en_i) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + V_ONE;
    end else begin
      h_d = h_q + H_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign de_o          = (h_q < H_ACT_C) && (v_q < V_ACT_C);
  assign hsync_o       = (h_q >= H_HS_BEG) && (h_q <= H_HS_LAST);
  assign vsync_o       = (v_q >= V_VS_BEG) && (v_q <= V_VS_LAST);
  assign frame_start_o = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/dp_timing_src.sv
// rtl/dp_timing_src.sv - DP raster timing source packing RGB beats into the DP word
//
// Purpose: generates raster timing, pulls pixels from a valid/ready source, detects
// underflow and frame misalignment, blanks bad pixels and resyncs on the next frame.
// Ports:
//   clk, rst_n        pixel clock, synchronous active-low reset
//   en                0: raster held at origin, DPo=0, FSM to IDLE
//   pix_valid/sof/data/ready  pixel source handshake ({R,G,B} data)
//   clr_err           clears sticky flags (a new error in the same cycle wins)
//   DPo               registered {hsync,vsync,de,R,G,B}
//   underflow         sticky: source not valid on a RUN active pixel
//   sof_err           sticky: sof beat at the wrong raster position

module dp_timing_src
  import dp_pkg::*;
#(
  parameter int H_ACT  = DP_H_ACT,
  parameter int H_FP   = DP_H_FP,
  parameter int H_SYNC = DP_H_SYNC,
  parameter int H_BP   = DP_H_BP,
  parameter int V_ACT  = DP_V_ACT,
  parameter int V_FP   = DP_V_FP,
  parameter int V_SYNC = DP_V_SYNC,
  parameter int V_BP   = DP_V_BP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            pix_valid,
  input  logic            pix_sof,
  input  logic [23:0]     pix_data,
  output logic            pix_ready,
  input  logic            clr_err,
  output logic [DP_W-1:0] DPo,
  output logic            underflow,
  output logic            sof_err
);

  logic de, hsync, vsync, frame_start;

  dp_raster_cnt #(
    .H_ACT (H_ACT),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
    .V_ACT (V_ACT),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
  ) u_raster (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .en_i          (en),
    .de_o          (de),
    .hsync_o       (hsync),
    .vsync_o       (vsync),
    .frame_start_o (frame_start)
  );

  dp_state_e       state_q, state_d;
  logic [DP_W-1:0] dpo_q, dpo_d;
  logic            und_q, und_d;
  logic            serr_q, serr_d;
  logic [23:0]     rgb;
  logic            new_und, new_serr;

  always_comb begin
    state_d   = state_q;
    pix_ready = 1'b0;
    rgb       = '0;
    new_und   = 1'b0;
    new_serr  = 1'b0;
    // No beat is taken while reset or disable is applied.
    if (!rst_n || !en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = WAIT_SOF;
        WAIT_SOF: begin
          // Only the sof beat, and only at the frame origin, is taken here.
          if (frame_start && pix_valid && pix_sof) begin
            pix_ready = 1'b1;
            rgb       = pix_data;
            state_d   = RUN;
          end
        end
        RUN: begin
          pix_ready = de;
          if (de) begin
            if (!pix_valid) begin
              new_und = 1'b1;
            end else if (pix_sof != frame_start) begin
              new_serr = 1'b1;
              state_d  = RESYNC;
            end else begin
              rgb = pix_data;
            end
          end
        end
        RESYNC: begin
          // Drain non-sof beats; the sof beat stays at the head for WAIT_SOF.
          pix_ready = pix_valid && !pix_sof;
          if (pix_valid && pix_sof) begin
            state_d = WAIT_SOF;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    dpo_d = '0;
    if (en) begin
      dpo_d[DP_HS]             = hsync;
      dpo_d[DP_VS]             = vsync;
      dpo_d[DP_DE]             = de;
      dpo_d[DP_R_HI:DP_B_LO]   = rgb;
    end

    und_d  = (und_q  && !clr_err) || new_und;
    serr_d = (serr_q && !clr_err) || new_serr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dpo_q   <= '0;
      und_q   <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dpo_q   <= dpo_d;
      und_q   <= und_d;
      serr_q  <= serr_d;
    end
  end

  assign DPo       = dpo_q;
  assign underflow = und_q;
  assign sof_err   = serr_q;

endmodule

// File: tb/tb_dp_timing_src.sv
// tb/tb_dp_timing_src.sv - self-checking bench for dp_timing_src with a reduced raster

module tb_dp_timing_src;

  localparam int H_ACT = 8, H_FP = 2, H_SYNC = 2, H_BP = 2;
  localparam int V_ACT = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int F_TOT = H_TOT * V_TOT;
  localparam int F_PIX = H_ACT * V_ACT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, en = 1'b0, pix_valid = 1'b0, pix_sof = 1'b0, clr_err = 1'b0;
  logic [23:0] pix_data = '0;
  logic        pix_ready, underflow, sof_err;
  logic [26:0] DPo;

  always #5 clk = ~clk;

  dp_timing_src #(
    .H_ACT (H_ACT), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACT (V_ACT), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .clr_err   (clr_err),
    .DPo       (DPo),
    .underflow (underflow),
    .sof_err   (sof_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pixel source: a queue of beats, whole frames with sof on the first pixel.
  typedef struct packed {
    logic        sof;
    logic [23:0] data;
  } beat_t;
  beat_t src_q[$];

  task automatic push_frame();
    beat_t b;
    for (int i = 0; i < F_PIX; i++) begin
      b.sof  = (i == 0);
      b.data = 24'($urandom());
      src_q.push_back(b);
    end
  endtask

  task automatic flush_src();
    src_q.delete();
    push_frame();
  endtask

  // Reference model: raster position is a cycle index into the frame,
  // decoded with plain division/modulo.
  typedef enum int {M_IDLE, M_WAIT, M_RUN, M_RESYNC} m_mode_e;
  int          m_pos = 0;
  m_mode_e     m_mode = M_IDLE;
  bit          m_und = 0, m_serr = 0;
  logic [26:0] m_dpo = '0;

  function automatic int m_h();
    return m_pos % H_TOT;
  endfunction

  function automatic int m_v();
    return m_pos / H_TOT;
  endfunction

  function automatic bit m_de();
    return (m_h() < H_ACT) && (m_v() < V_ACT);
  endfunction

  function automatic bit model_ready(bit r, bit e, bit valid, bit sof);
    if (!r || !e) return 1'b0;
    case (m_mode)
      M_IDLE:  return 1'b0;
      M_WAIT:  return (m_pos == 0) && valid && sof;
      M_RUN:   return m_de();
      default: return valid && !sof;
    endcase
  endfunction

  task automatic model_step(bit r, bit e, bit valid, bit sof, logic [23:0] data, bit clr);
    int h = m_h();
    int v = m_v();
    bit de = m_de();
    bit hs = (h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SYNC);
    bit vs = (v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SYNC);
    bit acc = model_ready(r, e, valid, sof) && valid;
    logic [23:0] rgb = '0;
    bit nu = 0, ns = 0;
    if (!r) begin
      m_pos = 0; m_mode = M_IDLE; m_und = 0; m_serr = 0; m_dpo = '0;
      return;
    end
    if (!e) begin
      m_pos = 0; m_mode = M_IDLE; m_dpo = '0;
      m_und = m_und && !clr; m_serr = m_serr && !clr;
      return;
    end
    case (m_mode)
      M_IDLE: m_mode = M_WAIT;
      M_WAIT: if (acc) begin rgb = data; m_mode = M_RUN; end
      M_RUN: begin
        if (de && !valid) nu = 1;
        else if (acc) begin
          if (sof != (m_pos == 0)) begin ns = 1; m_mode = M_RESYNC; end
          else rgb = data;
        end
      end
      default: if (valid && sof) m_mode = M_WAIT;
    endcase
    m_und  = nu || (m_und && !clr);
    m_serr = ns || (m_serr && !clr);
    m_dpo  = {hs, vs, de, rgb};
    m_pos  = (m_pos + 1) % F_TOT;
  endtask

  // One clock: drive at the falling edge, check ready, then check registered outputs after the rising edge.
  task automatic cycle(bit r, bit e, bit clr, bit g, bit fsof);
    beat_t b;
    bit    rdy;
    @(negedge clk);
    b = (src_q.size() > 0) ? src_q[0] : '0;
    rst_n     = r;
    en        = e;
    clr_err   = clr;
    pix_valid = g && (src_q.size() > 0);
    pix_sof   = b.sof | fsof;
    pix_data  = b.data;
    #1;
    rdy = model_ready(r, e, pix_valid, pix_sof);
    check("pix_ready", pix_ready, rdy);
    if (rdy && pix_valid) b = src_q.pop_front();
    model_step(r, e, pix_valid, pix_sof, pix_data, clr);
    @(posedge clk);
    #1;
    check("DPo", DPo, m_dpo);
    check("underflow", underflow, m_und);
    check("sof_err", sof_err, m_serr);
    if (src_q.size() < F_PIX) push_frame();
  endtask

  task automatic run_until(int h, int v);
    int k = 0;
    while (!(m_h() == h && m_v() == v) && k < 2 * F_TOT) begin
      cycle(1, 1, 0, 1, 0);
      k++;
    end
    check("reach_pos", (m_h() == h && m_v() == v), 1);
  endtask

  typedef struct {
    bit          r, e, valid, sof, clr;
    logic [23:0] data;
    bit          exp_rdy;
    logic [26:0] exp_dpo;
    bit          exp_und, exp_serr;
  } vec_t;

  vec_t        vecs[6];
  logic [23:0] hold;
  logic [23:0] exp_pix[F_PIX];
  int          n_de, n_hs, n_vs, pix_idx;

  initial begin
    vecs[0] = '{r:0, e:1, valid:0, sof:0, clr:0, data:24'h0,      exp_rdy:0, exp_dpo:27'h0,       exp_und:0, exp_serr:0};
    vecs[1] = '{r:1, e:0, valid:1, sof:1, clr:0, data:24'h123456, exp_rdy:0, exp_dpo:27'h0,       exp_und:0, exp_serr:0};
    vecs[2] = '{r:1, e:1, valid:1, sof:1, clr:0, data:24'h123456, exp_rdy:0, exp_dpo:27'h1000000, exp_und:0, exp_serr:0};
    vecs[3] = '{r:1, e:1, valid:1, sof:1, clr:1, data:24'habcdef, exp_rdy:0, exp_dpo:27'h1000000, exp_und:0, exp_serr:0};
    vecs[4] = '{r:1, e:0, valid:1, sof:1, clr:0, data:24'habcdef, exp_rdy:0, exp_dpo:27'h0,       exp_und:0, exp_serr:0};
    vecs[5] = '{r:1, e:1, valid:0, sof:0, clr:0, data:24'h0,      exp_rdy:0, exp_dpo:27'h1000000, exp_und:0, exp_serr:0};

    // Reset, enable/disable around the origin: expectations are hand-derived constants.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rst_n = vecs[i].r; en = vecs[i].e; pix_valid = vecs[i].valid;
      pix_sof = vecs[i].sof; pix_data = vecs[i].data; clr_err = vecs[i].clr;
      #1;
      check("vec_ready", pix_ready, vecs[i].exp_rdy);
      model_step(vecs[i].r, vecs[i].e, vecs[i].valid, vecs[i].sof, vecs[i].data, vecs[i].clr);
      @(posedge clk);
      #1;
      check("vec_dpo", DPo, vecs[i].exp_dpo);
      check("vec_und", underflow, vecs[i].exp_und);
      check("vec_serr", sof_err, vecs[i].exp_serr);
    end
    flush_src();

    // Always-valid source: one full frame of raster and pixel order.
    run_until(0, 0);
    for (int i = 0; i < F_PIX; i++) exp_pix[i] = src_q[i].data;
    n_de = 0; n_hs = 0; n_vs = 0; pix_idx = 0;
    for (int i = 0; i < F_TOT; i++) begin
      cycle(1, 1, 0, 1, 0);
      n_hs += int'(DPo[26]);
      n_vs += int'(DPo[25]);
      if (DPo[24]) begin
        if (pix_idx < F_PIX) check("s1_pixel_order", DPo[23:0], exp_pix[pix_idx]);
        n_de++;
        pix_idx++;
      end
    end
    check("s1_de_count", n_de, F_PIX);
    check("s1_hs_count", n_hs, H_SYNC * V_TOT);
    check("s1_vs_count", n_vs, V_SYNC * H_TOT);
    check("s1_flags", {underflow, sof_err}, 2'b00);

    // One-cycle source gap on an active pixel.
    run_until(3, 1);
    hold = src_q[0].data;
    cycle(1, 1, 0, 0, 0);
    check("s2_underflow", underflow, 1);
    check("s2_de", DPo[24], 1);
    check("s2_rgb_blank", DPo[23:0], 0);
    cycle(1, 1, 0, 1, 0);
    check("s2_next_pixel", DPo[23:0], hold);
    cycle(1, 1, 1, 1, 0);

    // Stray sof mid-frame, drain, resume at the next frame origin.
    run_until(5, 2);
    cycle(1, 1, 0, 1, 1);
    check("s3_sof_err", sof_err, 1);
    check("s3_rgb_blank", DPo[23:0], 0);
    run_until(0, 0);
    hold = src_q[0].data;
    cycle(1, 1, 0, 1, 0);
    check("s3_resume_pixel", DPo[23:0], hold);
    cycle(1, 1, 1, 1, 0);

    // Reset pulse mid-frame with a flag set beforehand.
    run_until(2, 3);
    cycle(1, 1, 0, 0, 0);
    run_until(6, 3);
    cycle(0, 1, 0, 1, 0);
    check("s4_dpo_zero", DPo, 0);
    check("s4_flags_zero", {underflow, sof_err}, 2'b00);
    flush_src();
    cycle(1, 1, 0, 1, 0);
    check("s4_origin", DPo, 27'h1000000);
    run_until(0, 0);
    hold = src_q[0].data;
    cycle(1, 1, 0, 1, 0);
    check("s4_resume_pixel", DPo[23:0], hold);

    // Enable dropped for three cycles mid-line.
    run_until(4, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 1, 0);
      check("s5_dpo_zero", DPo, 0);
      check("s5_ready_zero", pix_ready, 0);
    end
    flush_src();
    cycle(1, 1, 0, 1, 0);
    check("s5_origin", DPo, 27'h1000000);
    run_until(0, 0);
    hold = src_q[0].data;
    cycle(1, 1, 0, 1, 0);
    check("s5_resume_pixel", DPo[23:0], hold);

    // Clear racing a new underflow: the set wins.
    run_until(2, 2);
    cycle(1, 1, 1, 0, 0);
    check("s6_set_wins", underflow, 1);
    cycle(1, 1, 1, 1, 0);
    check("s6_cleared", underflow, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 6 * F_TOT; i++) begin
      bit r  = ($urandom_range(0, 299) != 0);
      bit e  = ($urandom_range(0, 149) != 0);
      bit c  = ($urandom_range(0, 39) == 0);
      bit g  = ($urandom_range(0, 9) != 0);
      bit fs = ($urandom_range(0, 59) == 0);
      cycle(r, e, c, g, fs);
      if (!r || !e) flush_src();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
